dot_update_queue: RTL and testbench
===================================

// Module: dot_update_queue
// PURPOSE
//  Consumer end of the processor's dot-location MMIO write path. Pairs the X write and
//  Y write for each dot into one {id,x,y} update and buffers it in a FIFO. Updates drain
//  to the VGA dot table only while the frame is in blanking, so no dot tears mid-frame.
//  Sits between the MMIO address decode (dotWren/is_Yloc/dotID/dotLoc) and the VGA dot store.
// PARAMETERS
//  ID_W   6   dot index width; valid ids 0..2**ID_W-1
//  LOC_W  10  coordinate width; the low LOC_W bits of dotLoc are kept
//  DEPTH  16  FIFO entries; must be a power of two, >=2
// PORTS
//  clock       in   1              system clock; all state changes on posedge
//  reset       in   1              synchronous, active-high; flushes everything
//  dotWren     in   1              MMIO dot write strobe, one cycle per store
//  is_Yloc     in   1              1 = Y coordinate write, 0 = X coordinate write
//  dotID       in   32             dot index from address offset
//  dotLoc      in   32             coordinate data from processor
//  frame_blank in   1              1 while VGA is in vertical blanking
//  upd_valid   out  1              head entry available and frame_blank=1
//  upd_ready   in   1              VGA dot store accepts head this cycle
//  upd_id      out  ID_W           head entry dot id
//  upd_x       out  LOC_W          head entry X
//  upd_y       out  LOC_W          head entry Y
//  count       out  clog2(DEPTH)+1 entries currently held
//  ovf         out  1              sticky: a completed pair was dropped because the FIFO was full
//  perr        out  1              sticky: Y with no matching pending X, or id out of range
//  clear_err   in   1              one-cycle pulse clears ovf and perr
// BEHAVIOUR
//  Reset: count=0, upd_valid=0, upd_id/x/y=0, ovf=0, perr=0, x_pend=0; head/tail pointers=0.
//  A reset pulse in mid-operation discards queued entries and any pending X.
//  Id check: a write with dotID >= 2**ID_W is ignored, sets perr, and does not touch x_pend.
//  X write (dotWren & !is_Yloc): x_hold<=dotLoc[LOC_W-1:0], x_id<=dotID, x_pend<=1.
//   A second X before its Y overwrites the first; no error is flagged.
//  Y write (dotWren & is_Yloc):
//   - x_pend & dotID==x_id: push {x_id,x_hold,dotLoc[LOC_W-1:0]}; x_pend<=0.
//   - otherwise: nothing is pushed; perr<=1; x_pend is unchanged.
//  Push when full: if there is no pop in the same cycle, the entry is dropped, ovf<=1,
//   x_pend<=0. If a pop occurs in the same cycle, the push succeeds and count stays at DEPTH.
//  Drain: upd_valid = (count!=0) & frame_blank, combinational. upd_id/x/y always show the
//   head entry and hold their last value when the FIFO is empty.
//   A pop occurs on posedge when upd_valid & upd_ready.
//   upd_valid may drop without a pop when frame_blank falls. The sink must not rely on
//   AXI-style valid persistence.
//  Latency: an entry pushed at edge N is visible at the head and shows upd_valid at N+1
//   when it was the only entry and frame_blank=1. Throughput is one pop per cycle.
//  Simultaneous push and pop: count is unchanged. Pointers wrap modulo DEPTH.
//   count = DEPTH means full; count = 0 means empty.
//  clear_err: clears ovf and perr. If a new error occurs in the same cycle, the set wins.
//  Width rules: dotLoc[31:LOC_W] and dotID[31:ID_W] are ignored beyond the range check.
// TESTING
//  1. X(id3,x=100) then Y(id3,y=50), frame_blank=1, upd_ready=1 -> one cycle later
//     upd_valid=1 with id=3,x=100,y=50; it pops; count returns to 0.
//  2. X(id1,10), X(id1,20), Y(id1,30) -> single entry {1,20,30}, perr=0.
//     Y(id2,5) with no pending X -> no push, perr=1. clear_err -> perr=0.
//  3. Push 16 pairs with frame_blank=0 -> count=16, upd_valid=0. A 17th pair -> ovf=1,
//     count=16. Set blank=1, ready=1 -> 16 pops in order, ids 0..15.
//  4. FIFO full, blank=1, ready=1, and a Y completes a pair in the same cycle -> push
//     accepted, count stays 16, ovf=0, new entry is drained last.
//  5. Entries queued, frame_blank drops mid-drain -> upd_valid=0 and no pops.
//     blank returns -> drain resumes with the next entry, nothing lost or duplicated.
//  6. X(id=64) with ID_W=6 -> perr=1, x_pend unchanged. Reset with 5 queued and an X
//     pending -> next cycle count=0, ovf=perr=0. A following Y makes no push (perr=1).

Source files
------------

// File: rtl/dot_update_queue_if.sv
// MMIO dot-write side and VGA dot-store update side of the dot update queue.
// slave is the queue's view; master is the processor/VGA-side view.
interface dot_update_queue_if #(
  parameter int ID_W  = 6,
  parameter int LOC_W = 10
);
  logic              dotWren;
  logic              is_Yloc;
  logic [31:0]       dotID;
  logic [31:0]       dotLoc;
  logic              upd_valid;
  logic              upd_ready;
  logic [ID_W-1:0]   upd_id;
  logic [LOC_W-1:0]  upd_x;
  logic [LOC_W-1:0]  upd_y;

  modport slave (
    input  dotWren, is_Yloc, dotID, dotLoc, upd_ready,
    output upd_valid, upd_id, upd_x, upd_y
  );

  modport master (
    output dotWren, is_Yloc, dotID, dotLoc, upd_ready,
    input  upd_valid, upd_id, upd_x, upd_y
  );
endinterface

// File: rtl/dot_update_queue.sv
// Pairs MMIO X/Y dot-coordinate writes into {id,x,y} updates, queues them, and
// releases them to the VGA dot table only during vertical blanking.
module dot_update_queue #(
  parameter int ID_W  = 6,
  parameter int LOC_W = 10,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  dot_update_queue_if.slave bus,
  input  logic              frame_blank,
  input  logic              clear_err,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic              perr
);
  localparam int E_W = ID_W + 2 * LOC_W;

  logic [E_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             x_pend_q, x_pend_d;
  logic             ovf_q, ovf_d;
  logic             perr_q, perr_d;
  logic [E_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]  x_id_q;
  logic [LOC_W-1:0] x_hold_q;

  logic             id_ok, x_wr, pair, bad;
  logic             empty, full, pop, push, drop;
  logic [E_W-1:0]   head, shown;
  logic             unused_hi;

  // Upper address/data bits only matter for the id range check.
  assign unused_hi = ^bus.dotLoc[31:LOC_W];

  assign id_ok = (bus.dotID[31:ID_W] == '0);
  assign x_wr  = bus.dotWren & ~bus.is_Yloc & id_ok;
  assign pair  = bus.dotWren & bus.is_Yloc & id_ok & x_pend_q
               & (bus.dotID[ID_W-1:0] == x_id_q);
  assign bad   = bus.dotWren & (~id_ok | (bus.is_Yloc & ~pair));

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign pop   = bus.upd_valid & bus.upd_ready;
  assign push  = pair & (~full | pop);
  assign drop  = pair & full & ~pop;

  // Outputs show the head, or the last popped entry once the queue runs dry.
  assign head          = mem_q[rd_ptr_q];
  assign shown         = empty ? last_q : head;
  assign bus.upd_valid = ~empty & frame_blank;
  assign bus.upd_id    = shown[E_W-1 -: ID_W];
  assign bus.upd_x     = shown[2*LOC_W-1 -: LOC_W];
  assign bus.upd_y     = shown[LOC_W-1:0];
  assign count         = count_q;
  assign ovf           = ovf_q;
  assign perr          = perr_q;

  always_comb begin
    x_pend_d = x_pend_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (x_wr) x_pend_d = 1'b1;
    if (pair) x_pend_d = 1'b0;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = head;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A new error in the clearing cycle still sets the flag.
    ovf_d  = (ovf_q & ~clear_err) | drop;
    perr_d = (perr_q & ~clear_err) | bad;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      x_pend_q <= 1'b0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      x_pend_q <= x_pend_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
      last_q   <= last_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count and x_pend.
  always_ff @(posedge clock) begin
    if (x_wr) begin
      x_hold_q <= bus.dotLoc[LOC_W-1:0];
      x_id_q   <= bus.dotID[ID_W-1:0];
    end
    if (push) mem_q[wr_ptr_q] <= {x_id_q, x_hold_q, bus.dotLoc[LOC_W-1:0]};
  end
endmodule

// File: tb/tb_dot_update_queue.sv
// Randomised and directed bench for dot_update_queue against a queue-based model.
module tb_dot_update_queue;
  localparam int ID_W  = 6;
  localparam int LOC_W = 10;
  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset, frame_blank, clear_err;
  logic [4:0] count;
  logic       ovf, perr;

  dot_update_queue_if #(.ID_W(ID_W), .LOC_W(LOC_W)) bus ();

  dot_update_queue #(.ID_W(ID_W), .LOC_W(LOC_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave), .frame_blank(frame_blank),
    .clear_err(clear_err), .count(count), .ovf(ovf), .perr(perr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [LOC_W-1:0] x;
    logic [LOC_W-1:0] y;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_last;
  bit          m_xpend, m_ovf, m_perr;
  logic [31:0] m_xid;
  logic [LOC_W-1:0] m_xhold;
  int          checks = 0;
  int          errors = 0;

  // Model of one clock edge, applied with the inputs that were present at that edge.
  task automatic model_edge(input bit wr, isy, input logic [31:0] id, loc,
                            input bit blank, rdy, clr, rst);
    bit pop, pair, err, ovfset;
    int was;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_last = '{0, 0, 0};
      m_xpend = 0; m_ovf = 0; m_perr = 0;
      return;
    end
    was = mq.size();
    pop = (was != 0) && blank && rdy;
    pair = 0; err = 0; ovfset = 0;
    if (wr) begin
      if (id >= 32'd64) err = 1;
      else if (!isy) begin
        m_xpend = 1; m_xid = id; m_xhold = loc[LOC_W-1:0];
      end else if (m_xpend && id == m_xid) pair = 1;
      else err = 1;
    end
    if (pop) m_last = mq.pop_front();
    if (pair) begin
      m_xpend = 0;
      e.id = m_xid[ID_W-1:0]; e.x = m_xhold; e.y = loc[LOC_W-1:0];
      if (was < DEPTH || pop) mq.push_back(e);
      else ovfset = 1;
    end
    m_ovf  = (m_ovf && !clr) || ovfset;
    m_perr = (m_perr && !clr) || err;
  endtask

  task automatic step(input bit wr, isy, input logic [31:0] id, loc,
                      input bit blank, rdy, clr, rst);
    bus.dotWren = wr; bus.is_Yloc = isy; bus.dotID = id; bus.dotLoc = loc;
    frame_blank = blank; bus.upd_ready = rdy; clear_err = clr; reset = rst;
    @(posedge clock);
    model_edge(wr, isy, id, loc, blank, rdy, clr, rst);
    #1;
  endtask

  task automatic xw(input logic [31:0] id, loc, input bit blank, rdy);
    step(1, 0, id, loc, blank, rdy, 0, 0);
  endtask
  task automatic yw(input logic [31:0] id, loc, input bit blank, rdy);
    step(1, 1, id, loc, blank, rdy, 0, 0);
  endtask
  task automatic idle(input bit blank, rdy);
    step(0, 0, 0, 0, blank, rdy, 0, 0);
  endtask

  task automatic test_reset;
    step(0, 0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0, 1);
    idle(1, 0);
    checks++;
    if (count !== 5'd0 || bus.upd_valid !== 1'b0 || ovf !== 1'b0 || perr !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got count=%0d valid=%b ovf=%b perr=%b want 0 0 0 0",
               count, bus.upd_valid, ovf, perr);
    end
    checks++;
    if (bus.upd_id !== '0 || bus.upd_x !== '0 || bus.upd_y !== '0) begin
      errors++;
      $display("FAIL reset_head got %0d/%0d/%0d want 0/0/0", bus.upd_id, bus.upd_x, bus.upd_y);
    end
  endtask

  task automatic test_basic;
    xw(3, 100, 1, 1);
    yw(3, 50, 1, 1);
    checks++;
    if (bus.upd_valid !== 1'b1 || bus.upd_id !== 6'd3 || bus.upd_x !== 10'd100 ||
        bus.upd_y !== 10'd50 || count !== 5'd1) begin
      errors++;
      $display("FAIL basic_head got v=%b id=%0d x=%0d y=%0d cnt=%0d want 1 3 100 50 1",
               bus.upd_valid, bus.upd_id, bus.upd_x, bus.upd_y, count);
    end
    idle(1, 1);
    checks++;
    if (count !== 5'd0 || bus.upd_valid !== 1'b0 || bus.upd_x !== 10'd100) begin
      errors++;
      $display("FAIL basic_pop got cnt=%0d v=%b x=%0d want 0 0 100", count, bus.upd_valid, bus.upd_x);
    end
  endtask

  task automatic test_pairing;
    xw(1, 10, 0, 0);
    xw(1, 20, 0, 0);
    yw(1, 30, 0, 0);
    idle(1, 0);
    checks++;
    if (count !== 5'd1 || perr !== 1'b0 || bus.upd_valid !== 1'b1 || bus.upd_id !== 6'd1 ||
        bus.upd_x !== 10'd20 || bus.upd_y !== 10'd30) begin
      errors++;
      $display("FAIL overwrite got cnt=%0d perr=%b v=%b %0d/%0d/%0d want 1 0 1 1/20/30",
               count, perr, bus.upd_valid, bus.upd_id, bus.upd_x, bus.upd_y);
    end
    yw(2, 5, 1, 0);
    checks++;
    if (perr !== 1'b1 || count !== 5'd1) begin
      errors++;
      $display("FAIL orphan_y got perr=%b cnt=%0d want 1 1", perr, count);
    end
    step(0, 0, 0, 0, 1, 0, 1, 0);
    checks++;
    if (perr !== 1'b0) begin
      errors++;
      $display("FAIL clear_err got perr=%b want 0", perr);
    end
    yw(9, 1, 1, 0);
    step(1, 1, 9, 1, 1, 1, 1, 0);
    checks++;
    if (perr !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("FAIL clear_vs_set got perr=%b cnt=%0d want 1 0", perr, count);
    end
    step(0, 0, 0, 0, 1, 1, 1, 0);
  endtask

  task automatic test_fill_ovf;
    for (int i = 0; i < DEPTH; i++) begin
      xw(i, i * 3 + 1, 0, 1);
      yw(i, i + 500, 0, 1);
    end
    checks++;
    if (count !== 5'd16 || bus.upd_valid !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL fill got cnt=%0d v=%b ovf=%b want 16 0 0", count, bus.upd_valid, ovf);
    end
    xw(20, 7, 0, 1);
    yw(20, 8, 0, 1);
    checks++;
    if (count !== 5'd16 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf got cnt=%0d ovf=%b want 16 1", count, ovf);
    end
    frame_blank = 1; bus.upd_ready = 1; #1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (bus.upd_valid !== 1'b1 || bus.upd_id !== i[ID_W-1:0] ||
          bus.upd_x !== 10'(i * 3 + 1) || bus.upd_y !== 10'(i + 500)) begin
        errors++;
        $display("FAIL drain_order got v=%b id=%0d x=%0d y=%0d want 1 %0d %0d %0d",
                 bus.upd_valid, bus.upd_id, bus.upd_x, bus.upd_y, i, i * 3 + 1, i + 500);
      end
      idle(1, 1);
    end
    checks++;
    if (count !== 5'd0 || bus.upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty got cnt=%0d v=%b want 0 0", count, bus.upd_valid);
    end
    step(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_full_simul;
    for (int i = 0; i < DEPTH; i++) begin
      xw(i, i, 0, 0);
      yw(i, i, 0, 0);
    end
    xw(40, 7, 0, 0);
    yw(40, 9, 1, 1);
    checks++;
    if (count !== 5'd16 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop got cnt=%0d ovf=%b want 16 0", count, ovf);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (bus.upd_id !== ((i == DEPTH) ? 6'd40 : i[ID_W-1:0])) begin
        errors++;
        $display("FAIL full_order got id=%0d want %0d", bus.upd_id, (i == DEPTH) ? 40 : i);
      end
      idle(1, 1);
    end
    checks++;
    if (count !== 5'd0 || bus.upd_x !== 10'd7 || bus.upd_y !== 10'd9) begin
      errors++;
      $display("FAIL full_last got cnt=%0d x=%0d y=%0d want 0 7 9", count, bus.upd_x, bus.upd_y);
    end
  endtask

  task automatic test_blank_pause;
    for (int i = 10; i < 14; i++) begin
      xw(i, i, 0, 1);
      yw(i, 2 * i, 0, 1);
    end
    idle(1, 1);
    idle(1, 1);
    idle(0, 1);
    idle(0, 1);
    checks++;
    if (bus.upd_valid !== 1'b0 || count !== 5'd2) begin
      errors++;
      $display("FAIL blank_pause got v=%b cnt=%0d want 0 2", bus.upd_valid, count);
    end
    frame_blank = 1; #1;
    checks++;
    if (bus.upd_valid !== 1'b1 || bus.upd_id !== 6'd12 || bus.upd_y !== 10'd24) begin
      errors++;
      $display("FAIL blank_resume got v=%b id=%0d y=%0d want 1 12 24", bus.upd_valid, bus.upd_id, bus.upd_y);
    end
    idle(1, 1);
    checks++;
    if (bus.upd_id !== 6'd13 || count !== 5'd1) begin
      errors++;
      $display("FAIL blank_next got id=%0d cnt=%0d want 13 1", bus.upd_id, count);
    end
    idle(1, 1);
  endtask

  task automatic test_range_reset;
    xw(5, 33, 0, 0);
    xw(64, 77, 0, 0);
    checks++;
    if (perr !== 1'b1) begin
      errors++;
      $display("FAIL range_perr got perr=%b want 1", perr);
    end
    yw(5, 44, 1, 0);
    checks++;
    if (count !== 5'd1 || bus.upd_id !== 6'd5 || bus.upd_x !== 10'd33 || bus.upd_y !== 10'd44) begin
      errors++;
      $display("FAIL range_keep got cnt=%0d %0d/%0d/%0d want 1 5/33/44",
               count, bus.upd_id, bus.upd_x, bus.upd_y);
    end
    for (int i = 0; i < 4; i++) begin
      xw(i, 1, 0, 0);
      yw(i, 2, 0, 0);
    end
    xw(7, 3, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1);
    checks++;
    if (count !== 5'd0 || ovf !== 1'b0 || perr !== 1'b0 || bus.upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got cnt=%0d ovf=%b perr=%b v=%b want 0 0 0 0",
               count, ovf, perr, bus.upd_valid);
    end
    yw(7, 4, 1, 0);
    checks++;
    if (count !== 5'd0 || perr !== 1'b1) begin
      errors++;
      $display("FAIL reset_xpend got cnt=%0d perr=%b want 0 1", count, perr);
    end
  endtask

  task automatic test_random;
    logic [31:0] id;
    ent_t e;
    for (int n = 0; n < 1500; n++) begin
      id = ($urandom_range(0, 19) == 0) ? 32'd64 + $urandom_range(0, 5000) : $urandom_range(0, 3);
      step($urandom_range(0, 1), $urandom_range(0, 1), id, $urandom,
           $urandom_range(0, 9) < 4, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
      e = (mq.size() != 0) ? mq[0] : m_last;
      checks++;
      if (count !== 5'(mq.size()) || ovf !== m_ovf || perr !== m_perr ||
          bus.upd_valid !== (mq.size() != 0 && frame_blank) ||
          bus.upd_id !== e.id || bus.upd_x !== e.x || bus.upd_y !== e.y) begin
        errors++;
        $display("FAIL random[%0d] got cnt=%0d ovf=%b perr=%b v=%b %0d/%0d/%0d want %0d %b %b %b %0d/%0d/%0d",
                 n, count, ovf, perr, bus.upd_valid, bus.upd_id, bus.upd_x, bus.upd_y,
                 mq.size(), m_ovf, m_perr, (mq.size() != 0 && frame_blank), e.id, e.x, e.y);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pairing();
    test_fill_ovf();
    test_full_simul();
    test_blank_pause();
    test_range_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
